// File: rtl/fft_ctrl_r4.sv
// Radix-4 DIF FFT address/sequence controller: per-stage butterfly read indices and twiddle
// exponents, a delayed write-side copy, and a digit-reversed unload.
module fft_ctrl_r4 #(
  parameter int unsigned LOG4_N   = 5,
  parameter int unsigned PIPE_LAT = 5,
  localparam int unsigned W  = 2 * LOG4_N,
  localparam int unsigned C  = W - 2,
  localparam int unsigned SW = 3
) (
  input  logic          iCLK,
  input  logic          iRESET,
  input  logic          iSTART,
  input  logic          iINVERSE,
  input  logic          iABORT,
  input  logic          iOUT_READY,
  output logic          oRDY,
  output logic [SW-1:0] oSTAGE,
  output logic          oRD_VALID,
  output logic [W-1:0]  oRD_IDX0,
  output logic [W-1:0]  oRD_IDX1,
  output logic [W-1:0]  oRD_IDX2,
  output logic [W-1:0]  oRD_IDX3,
  output logic          oRD_BANK,
  output logic [C-1:0]  oADDR_COEF,
  output logic          oCONJ,
  output logic          oWR_VALID,
  output logic [W-1:0]  oWR_IDX0,
  output logic [W-1:0]  oWR_IDX1,
  output logic [W-1:0]  oWR_IDX2,
  output logic [W-1:0]  oWR_IDX3,
  output logic          oWR_BANK,
  output logic          oOUT_VALID,
  output logic [W-1:0]  oOUT_IDX,
  output logic          oDONE
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StUnload} state_e;

  localparam logic [C-1:0]  TLast = '1;
  localparam logic [W-1:0]  ULast = '1;
  localparam logic [SW-1:0] SLast = SW'(LOG4_N - 1);
  localparam logic [3:0]    DLast = 4'(PIPE_LAT - 1);

  state_e              state_q;
  logic                rdy_q, conj_q, done_q;
  logic [SW-1:0]       stage_q, stage_nxt;
  logic [C-1:0]        t_q, t_nxt;
  logic [3:0]          d_q;
  logic [W-1:0]        u_q, u_nxt;
  logic                rd_valid_q, rd_bank_q;
  logic [3:0][W-1:0]   rd_idx_q;
  logic [C-1:0]        coef_q;
  logic                out_valid_q;
  logic [W-1:0]        out_idx_q;

  logic [SW-1:0]       ld_s;
  logic [C-1:0]        ld_t;
  logic [3:0][W-1:0]   ld_idx;
  logic [C-1:0]        ld_coef;

  logic                wr_valid_p [PIPE_LAT];
  logic                wr_bank_p  [PIPE_LAT];
  logic [3:0][W-1:0]   wr_idx_p   [PIPE_LAT];

  // Point index of leg k: g*4Q + k*Q + o with Q = 4^(LOG4_N-1-s)
  function automatic logic [W-1:0] dif_idx(input logic [SW-1:0] s, input logic [C-1:0] t,
                                           input int k);
    int unsigned sh;
    logic [W-1:0] tw, lo_mask;
    sh      = 2 * (LOG4_N - 1 - 32'(s));
    tw      = W'(t);
    lo_mask = (W'(1) << sh) - W'(1);
    return ((tw >> sh) << (sh + 2)) | (W'(k) << sh) | (tw & lo_mask);
  endfunction

  // Twiddle exponent o*4^s; at s=0 the mask wraps to all ones (o = t)
  function automatic logic [C-1:0] coef_of(input logic [SW-1:0] s, input logic [C-1:0] t);
    int unsigned sh;
    logic [C-1:0] lo_mask;
    sh      = 2 * (LOG4_N - 1 - 32'(s));
    lo_mask = (C'(1) << sh) - C'(1);
    return (t & lo_mask) << (2 * 32'(s));
  endfunction

  function automatic logic [W-1:0] digit_rev(input logic [W-1:0] u);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LOG4_N); i++) begin
      r[2*i +: 2] = u[2*(int'(LOG4_N)-1-i) +: 2];
    end
    return r;
  endfunction

  // Next butterfly to launch: first of a stage (idle/drain) or next t within the stage
  always_comb begin
    t_nxt     = t_q + C'(1);
    stage_nxt = stage_q + SW'(1);
    u_nxt     = u_q + W'(1);
    ld_s      = '0;
    ld_t      = '0;
    if (state_q == StRun) begin
      ld_s = stage_q;
      ld_t = t_nxt;
    end else if (state_q == StDrain) begin
      ld_s = stage_nxt;
    end
    for (int k = 0; k < 4; k++) begin
      ld_idx[k] = dif_idx(ld_s, ld_t, k);
    end
    ld_coef = coef_of(ld_s, ld_t);
  end

  // Sequencing FSM with registered outputs
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q     <= StIdle;
      rdy_q       <= 1'b1;
      conj_q      <= 1'b0;
      done_q      <= 1'b0;
      stage_q     <= '0;
      t_q         <= '0;
      d_q         <= '0;
      u_q         <= '0;
      rd_valid_q  <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      coef_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else if (iABORT) begin
      state_q     <= StIdle;
      rdy_q       <= 1'b1;
      conj_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (iSTART) begin
            state_q    <= StRun;
            rdy_q      <= 1'b0;
            conj_q     <= iINVERSE;
            stage_q    <= '0;
            t_q        <= '0;
            rd_valid_q <= 1'b1;
            rd_bank_q  <= ld_s[0];
            rd_idx_q   <= ld_idx;
            coef_q     <= ld_coef;
          end
        end
        StRun: begin
          if (t_q == TLast) begin
            state_q    <= StDrain;
            rd_valid_q <= 1'b0;
            d_q        <= '0;
          end else begin
            t_q      <= t_nxt;
            rd_idx_q <= ld_idx;
            coef_q   <= ld_coef;
          end
        end
        StDrain: begin
          // Wait out PIPE_LAT cycles so the stage's last write has been issued
          if (d_q == DLast) begin
            if (stage_q == SLast) begin
              // Final results sit in bank LOG4_N mod 2
              state_q     <= StUnload;
              u_q         <= '0;
              out_idx_q   <= '0;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= StRun;
              stage_q    <= stage_nxt;
              t_q        <= '0;
              rd_valid_q <= 1'b1;
              rd_bank_q  <= ld_s[0];
              rd_idx_q   <= ld_idx;
              coef_q     <= ld_coef;
            end
          end else begin
            d_q <= d_q + 4'd1;
          end
        end
        StUnload: begin
          if (done_q) begin
            state_q <= StIdle;
            rdy_q   <= 1'b1;
            conj_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (out_valid_q && iOUT_READY) begin
            if (u_q == ULast) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              u_q       <= u_nxt;
              out_idx_q <= digit_rev(u_nxt);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write-side shift pipeline; bank flips because results land in the other buffer
  always_ff @(posedge iCLK) begin
    if (iRESET || iABORT) begin
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        wr_valid_p[i] <= 1'b0;
        wr_bank_p[i]  <= 1'b0;
        wr_idx_p[i]   <= '0;
      end
    end else begin
      wr_valid_p[0] <= rd_valid_q;
      wr_bank_p[0]  <= ~rd_bank_q;
      wr_idx_p[0]   <= rd_idx_q;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        wr_valid_p[i] <= wr_valid_p[i-1];
        wr_bank_p[i]  <= wr_bank_p[i-1];
        wr_idx_p[i]   <= wr_idx_p[i-1];
      end
    end
  end

  assign oRDY       = rdy_q;
  assign oSTAGE     = stage_q;
  assign oRD_VALID  = rd_valid_q;
  assign oRD_IDX0   = rd_idx_q[0];
  assign oRD_IDX1   = rd_idx_q[1];
  assign oRD_IDX2   = rd_idx_q[2];
  assign oRD_IDX3   = rd_idx_q[3];
  assign oRD_BANK   = rd_bank_q;
  assign oADDR_COEF = coef_q;
  assign oCONJ      = conj_q;
  assign oWR_VALID  = wr_valid_p[PIPE_LAT-1];
  assign oWR_BANK   = wr_bank_p[PIPE_LAT-1];
  assign oWR_IDX0   = wr_idx_p[PIPE_LAT-1][0];
  assign oWR_IDX1   = wr_idx_p[PIPE_LAT-1][1];
  assign oWR_IDX2   = wr_idx_p[PIPE_LAT-1][2];
  assign oWR_IDX3   = wr_idx_p[PIPE_LAT-1][3];
  assign oOUT_VALID = out_valid_q;
  assign oOUT_IDX   = out_idx_q;
  assign oDONE      = done_q;

endmodule

// File: tb/tb_fft_ctrl_r4.sv
// Randomized bench for fft_ctrl_r4 against a timeline model of the transform.
module tb_fft_ctrl_r4;

  localparam int unsigned L  = 2;
  localparam int unsigned P  = 3;
  localparam int unsigned N  = 16;
  localparam int unsigned NQ = N / 4;
  localparam int unsigned SP = NQ + P;
  localparam int unsigned W  = 2 * L;
  localparam int unsigned C  = W - 2;
  localparam int unsigned SW = 3;

  logic          iCLK = 1'b0;
  logic          iRESET, iSTART, iINVERSE, iABORT, iOUT_READY;
  logic          oRDY, oRD_VALID, oRD_BANK, oCONJ, oWR_VALID, oWR_BANK, oOUT_VALID, oDONE;
  logic [SW-1:0] oSTAGE;
  logic [W-1:0]  oRD_IDX0, oRD_IDX1, oRD_IDX2, oRD_IDX3;
  logic [W-1:0]  oWR_IDX0, oWR_IDX1, oWR_IDX2, oWR_IDX3;
  logic [C-1:0]  oADDR_COEF;
  logic [W-1:0]  oOUT_IDX;

  always #5 iCLK = ~iCLK;

  fft_ctrl_r4 #(.LOG4_N(L), .PIPE_LAT(P)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iINVERSE(iINVERSE), .iABORT(iABORT),
    .iOUT_READY(iOUT_READY), .oRDY(oRDY), .oSTAGE(oSTAGE), .oRD_VALID(oRD_VALID),
    .oRD_IDX0(oRD_IDX0), .oRD_IDX1(oRD_IDX1), .oRD_IDX2(oRD_IDX2), .oRD_IDX3(oRD_IDX3),
    .oRD_BANK(oRD_BANK), .oADDR_COEF(oADDR_COEF), .oCONJ(oCONJ), .oWR_VALID(oWR_VALID),
    .oWR_IDX0(oWR_IDX0), .oWR_IDX1(oWR_IDX1), .oWR_IDX2(oWR_IDX2), .oWR_IDX3(oWR_IDX3),
    .oWR_BANK(oWR_BANK), .oOUT_VALID(oOUT_VALID), .oOUT_IDX(oOUT_IDX), .oDONE(oDONE)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: elapsed cycles since the accepted start, unload counter, done flag
  bit          m_busy, m_fresh, m_inv, m_done;
  int unsigned m_e, m_u;

  function automatic int unsigned pw4(input int unsigned x);
    int unsigned r = 1;
    for (int unsigned i = 0; i < x; i++) r = r * 4;
    return r;
  endfunction

  function automatic int unsigned m_idx(input int unsigned s, t, k);
    int unsigned q = pw4(L - 1 - s);
    return (t / q) * 4 * q + k * q + (t % q);
  endfunction

  function automatic int unsigned m_coef(input int unsigned s, t);
    return (t % pw4(L - 1 - s)) * pw4(s);
  endfunction

  function automatic int unsigned m_rev(input int unsigned u);
    int unsigned r = 0;
    int unsigned v = u;
    for (int unsigned i = 0; i < L; i++) begin
      r = r * 4 + v % 4;
      v = v / 4;
    end
    return r;
  endfunction

  task automatic check_outputs();
    bit rd_v, wr_v, out_v, in_unload;
    int unsigned rs, rt, ws, wt;
    in_unload = m_busy && (m_e > L * SP);
    rd_v  = m_busy && !in_unload && ((m_e - 1) % SP < NQ);
    wr_v  = m_busy && !in_unload && (m_e >= 1 + P) && ((m_e - 1 - P) % SP < NQ);
    out_v = in_unload && !m_done;
    check("rdy", oRDY, !m_busy);
    check("rd_valid", oRD_VALID, rd_v);
    check("wr_valid", oWR_VALID, wr_v);
    check("out_valid", oOUT_VALID, out_v);
    check("done", oDONE, in_unload && m_done);
    check("conj", oCONJ, m_busy ? m_inv : 1'b0);
    if (m_busy) check("stage", oSTAGE, in_unload ? L - 1 : (m_e - 1) / SP);
    if (rd_v) begin
      rs = (m_e - 1) / SP;
      rt = (m_e - 1) % SP;
      check("rd_idx0", oRD_IDX0, m_idx(rs, rt, 0));
      check("rd_idx1", oRD_IDX1, m_idx(rs, rt, 1));
      check("rd_idx2", oRD_IDX2, m_idx(rs, rt, 2));
      check("rd_idx3", oRD_IDX3, m_idx(rs, rt, 3));
      check("coef", oADDR_COEF, m_coef(rs, rt));
      check("rd_bank", oRD_BANK, rs % 2);
    end
    if (wr_v) begin
      ws = (m_e - 1 - P) / SP;
      wt = (m_e - 1 - P) % SP;
      check("wr_idx0", oWR_IDX0, m_idx(ws, wt, 0));
      check("wr_idx1", oWR_IDX1, m_idx(ws, wt, 1));
      check("wr_idx2", oWR_IDX2, m_idx(ws, wt, 2));
      check("wr_idx3", oWR_IDX3, m_idx(ws, wt, 3));
      check("wr_bank", oWR_BANK, 1 - ws % 2);
    end
    if (out_v) check("out_idx", oOUT_IDX, m_rev(m_u));
    if (m_fresh) begin
      check("rst_stage", oSTAGE, 0);
      check("rst_idx0", oRD_IDX0, 0);
      check("rst_coef", oADDR_COEF, 0);
      check("rst_out_idx", oOUT_IDX, 0);
    end
  endtask

  task automatic step_model(input bit st, inv, ab, rdy, rst);
    if (rst || ab) begin
      m_busy = 0;
      m_done = 0;
      if (rst) m_fresh = 1;
    end else if (!m_busy) begin
      if (st) begin
        m_busy  = 1;
        m_e     = 1;
        m_inv   = inv;
        m_u     = 0;
        m_done  = 0;
        m_fresh = 0;
      end
    end else if (m_e > L * SP) begin
      if (m_done) m_busy = 0;
      else if (rdy) begin
        if (m_u == N - 1) m_done = 1;
        else m_u++;
      end
      m_e++;
    end else begin
      m_e++;
    end
  endtask

  // Check the current cycle, then drive the inputs for the next rising edge
  task automatic cycle(input bit st, inv, ab, rdy, rst);
    @(negedge iCLK);
    check_outputs();
    iSTART     = st;
    iINVERSE   = inv;
    iABORT     = ab;
    iOUT_READY = rdy;
    iRESET     = rst;
    step_model(st, inv, ab, rdy, rst);
  endtask

  int done_k;

  initial begin
    iRESET = 1'b1; iSTART = 1'b0; iINVERSE = 1'b0; iABORT = 1'b0; iOUT_READY = 1'b1;
    m_busy = 0; m_fresh = 1; m_inv = 0; m_done = 0; m_e = 0; m_u = 0;
    repeat (2) @(posedge iCLK);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);

    // Inverse transform, ignored restart at cycle 5, 3-cycle stall at u=5
    done_k = -1;
    cycle(1, 1, 0, 1, 0);
    for (int k = 1; k <= 36; k++) begin
      cycle(k == 5, 0, 0, !(k >= 20 && k <= 22), 0);
      if (k == 2) begin
        check("d_idx1_t1", oRD_IDX1, 5);
        check("d_coef_t1", oADDR_COEF, 1);
      end
      if (k == 4) begin
        check("d_wr_idx3", oWR_IDX3, 12);
        check("d_wr_bank", oWR_BANK, 1);
      end
      if (k == 9) begin
        check("d_s1_stage", oSTAGE, 1);
        check("d_s1_idx0", oRD_IDX0, 4);
        check("d_s1_bank", oRD_BANK, 1);
      end
      if (k == 10) check("d_conj", oCONJ, 1);
      if (k == 16) check("d_out_u1", oOUT_IDX, 4);
      if (k == 23) check("d_out_hold", oOUT_IDX, 5);
      if (k == 35) check("d_rdy_after", oRDY, 1);
      if (oDONE === 1'b1 && done_k < 0) done_k = k;
    end
    check("d_done_cycle", done_k, 34);

    // Abort on cycle 9, then restart from stage 0
    cycle(1, 0, 0, 1, 0);
    for (int k = 1; k <= 9; k++) cycle(0, 0, k == 9, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check("a_rd_valid", oRD_VALID, 0);
    check("a_wr_valid", oWR_VALID, 0);
    check("a_rdy", oRDY, 1);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check("a_restart_stage", oSTAGE, 0);
    check("a_restart_idx2", oRD_IDX2, 8);

    // Randomized traffic with occasional aborts and one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(3) == 0, 1'($urandom), $urandom_range(149) == 0,
            $urandom_range(3) != 0, i == 1700);
    end
    cycle(0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_ctrl_r4.md
FFT_CTRL_R4 -- requirements
Module: fft_ctrl_r4

Interface
REQ-001 Parameter LOG4_N, default 5: FFT size N = 4^LOG4_N; legal range 2..6.
REQ-002 Parameter PIPE_LAT, default 5: cycles from a butterfly read to its result write; legal range 1..15.
REQ-003 Derived widths: W = 2*LOG4_N (point index), C = W-2 (twiddle address), SW = 3 (stage number).
REQ-004 iCLK  input  1  single clock; all logic on its rising edge.
REQ-005 iRESET  input  1  synchronous, active-high reset.
REQ-006 iSTART  input  1  start request; accepted only while oRDY=1.
REQ-007 iINVERSE  input  1  inverse-transform select, sampled with an accepted iSTART.
REQ-008 iABORT  input  1  abort the current transform.
REQ-009 iOUT_READY  input  1  unload sink ready.
REQ-010 oRDY  output  1  idle, ready for iSTART.
REQ-011 oSTAGE  output  SW  current read stage s, 0..LOG4_N-1.
REQ-012 oRD_VALID  output  1  read indices valid this cycle.
REQ-013 oRD_IDX0..oRD_IDX3  output  W each  butterfly input point indices.
REQ-014 oRD_BANK  output  1  ping-pong bank read (s[0]).
REQ-015 oADDR_COEF  output  C  twiddle exponent for leg 1; the datapath scales it by k for leg k.
REQ-016 oCONJ  output  1  latched iINVERSE; datapath conjugates the twiddles.
REQ-017 oWR_VALID, oWR_IDX0..3, oWR_BANK  output  1/W/1  write-side copies, delayed by PIPE_LAT.
REQ-018 oOUT_VALID  output  1, oOUT_IDX  output  W  unload read index in natural output order.
REQ-019 oDONE  output  1  one-cycle pulse when the unload completes.

Function
REQ-020 States: IDLE, RUN, DRAIN, UNLOAD; IDLE drives oRDY=1.
REQ-021 IDLE -> RUN on iSTART=1 and iABORT=0; s=0; butterfly counter t=0; oCONJ loads iINVERSE.
REQ-022 In RUN, oRD_VALID=1 for N/4 consecutive cycles, starting the cycle after the iSTART was accepted, with t = 0..N/4-1.
REQ-023 Radix-4 DIF indexing: Q = 4^(LOG4_N-1-s), g = t/Q, o = t mod Q.
REQ-024 oRD_IDXk = g*4Q + k*Q + o; oADDR_COEF = o*4^s; all index and coefficient outputs are registered.
REQ-025 oWR_* equal oRD_* (IDX, VALID, BANK) delayed by exactly PIPE_LAT cycles, using a shift pipeline; oWR_BANK = ~oRD_BANK at the time of the read.
REQ-026 After the last read of a stage: RUN -> DRAIN; oRD_VALID=0 until the last write of that stage has been issued.
REQ-027 On the cycle after the last write of stage s: if s < LOG4_N-1, s increments and RUN resumes with t=0; otherwise the FSM enters UNLOAD.
REQ-028 Stage period = N/4 + PIPE_LAT cycles; read and write in the same cycle is legal because they target opposite banks.
REQ-029 UNLOAD: counter u = 0..N-1; oOUT_VALID=1; oOUT_IDX = base-4 digit reversal of u; reads come from bank LOG4_N mod 2.
REQ-030 In UNLOAD, u advances only when oOUT_VALID and iOUT_READY are both 1; while iOUT_READY=0, oOUT_IDX holds its value.
REQ-031 When u=N-1 is accepted: oDONE=1 for one cycle; next cycle IDLE with oRDY=1.
REQ-032 iSTART outside IDLE is ignored; iINVERSE is ignored except with an accepted start.
REQ-033 iABORT=1 in any state: IDLE on the next cycle; all VALIDs low; write pipeline flushed; no oDONE. In IDLE, iABORT wins over a simultaneous iSTART.
REQ-034 Counters wrap only through FSM control, never by overflow; all arithmetic is unsigned at the declared widths.

Reset
REQ-035 iRESET=1 at a clock edge: state IDLE, oRDY=1; all other outputs 0 (including oCONJ and oSTAGE); the write pipeline is cleared.
REQ-036 Reset mid-transform behaves identically to REQ-035 and produces no oDONE.

Verification (LOG4_N=2, N=16, PIPE_LAT=3, iSTART accepted at cycle 0)
REQ-037 Stage 0: reads on cycles 1-4 give idx {0,4,8,12}..{3,7,11,15}, coef 0,1,2,3, oRD_BANK=0; writes on cycles 4-7 repeat the same indices with oWR_BANK=1.
REQ-038 Stage 1: reads on cycles 8-11, oSTAGE=1, t=1 -> idx {4,5,6,7}, coef 0, oRD_BANK=1; last write on cycle 14.
REQ-039 Unload with iOUT_READY=1: oOUT_VALID on cycles 15-30; oOUT_IDX for u=1,2,5,6 = 4,8,5,9; oDONE on cycle 31; oRDY=1 on cycle 32.
REQ-040 iOUT_READY=0 for 3 cycles at u=5: oOUT_IDX holds 5; oDONE is delayed by exactly 3 cycles.
REQ-041 iABORT on cycle 9: oRD_VALID and oWR_VALID are 0 from cycle 10; oRDY=1; no oDONE; a following iSTART restarts at stage 0.
REQ-042 iSTART on cycle 5 is ignored; iINVERSE=1 at the accepted start gives oCONJ=1 until IDLE.
